uart_param: RTL and testbench

Parametrised full-duplex UART, the successor to the fixed 8N1/115200 UART. It supports configurable baud rate, data width, parity and stop bits, and adds error detection and a first-word-fall-through RX FIFO of configurable depth. It sits between the FPGA fabric (LED/command logic) and the external serial pins, with the same start/busy TX handshake and read/ready RX handshake.

---
 rtl/uart_param_pkg.sv | 31 +++
 rtl/uart_sync_fifo.sv | 71 +++++++
 rtl/uart_param.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_param.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_param_pkg.sv
// Shared definitions for the parametrised UART: parity modes, FSM encodings
// and the bit-period computation.
package uart_param_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Clock cycles per serial bit, truncated.
    function automatic int unsigned bit_period(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head; push and
// pop in the same cycle are both honoured, even when full.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Write,
    input  logic [WIDTH-1:0]       i_Write_Data,
    input  logic                   i_Read,
    output logic [WIDTH-1:0]       o_Data,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Full,
    output logic                   o_Empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count_after_pop;
    logic [AW:0]      count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_pop;
    logic             do_push;

    // Next head: a push into an (effectively) empty FIFO bypasses the memory.
    always_comb begin
        do_pop          = i_Read && !o_Empty;
        do_push         = i_Write && (!o_Full || do_pop);
        rd_ptr_nxt      = rd_ptr + AW'(do_pop);
        count_after_pop = o_Count - (AW+1)'(do_pop);
        count_nxt       = count_after_pop + (AW+1)'(do_push);
        if (do_push && count_after_pop == '0) begin
            head_nxt = i_Write_Data;
        end else if (count_nxt != '0) begin
            head_nxt = mem[rd_ptr_nxt];
        end else begin
            head_nxt = o_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_Count <= '0;
            o_Empty <= 1'b1;
            o_Full  <= 1'b0;
            o_Data  <= '0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            o_Count <= count_nxt;
            o_Empty <= (count_nxt == '0);
            o_Full  <= (count_nxt == (AW+1)'(DEPTH));
            o_Data  <= head_nxt;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= i_Write_Data;
        end
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable baud, data width, parity and
// stop bits, with sticky error flags and an RX FIFO.
module uart_param
    import uart_param_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1,
    parameter int unsigned RX_FIFO_DEPTH   = 16
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic                           i_Start,
    input  logic [DATA_BITS-1:0]           i_Data,
    output logic                           o_TX,
    output logic                           o_Busy_TX,
    input  logic                           i_RX,
    input  logic                           i_Read_Data,
    output logic [DATA_BITS-1:0]           o_Data,
    output logic                           o_Data_Ready,
    output logic [$clog2(RX_FIFO_DEPTH):0] o_FIFO_Count,
    input  logic                           i_Clear_Errors,
    output logic                           o_Framing_Error,
    output logic                           o_Parity_Error,
    output logic                           o_Overrun
);
    localparam int unsigned BIT_PERIOD  = bit_period(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF_PERIOD = BIT_PERIOD / 2;
    localparam int unsigned CNT_W       = $clog2(BIT_PERIOD);
    localparam int unsigned IDX_W       = $clog2(DATA_BITS);
    localparam logic        ODD_INV     = (PARITY == PARITY_ODD);
    localparam logic        HAS_PARITY  = (PARITY != PARITY_NONE);

    // ---------------- TX ----------------
    tx_state_t            tx_state, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
    logic [IDX_W-1:0]     tx_idx, tx_idx_d;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic                 tx_par, tx_par_d;
    logic                 tx_d, busy_d;
    logic                 tx_bit_end;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            o_TX      <= 1'b1;
            o_Busy_TX <= 1'b0;
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_idx    <= tx_idx_d;
            tx_shift  <= tx_shift_d;
            tx_par    <= tx_par_d;
            o_TX      <= tx_d;
            o_Busy_TX <= busy_d;
        end
    end

    // The line value for each bit is registered on the edge that starts it.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_idx_d   = tx_idx;
        tx_shift_d = tx_shift;
        tx_par_d   = tx_par;
        tx_d       = o_TX;
        busy_d     = o_Busy_TX;
        tx_bit_end = (tx_cnt == CNT_W'(BIT_PERIOD - 1));
        if (tx_state != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
        end
        case (tx_state)
            TX_IDLE: begin
                if (i_Start) begin
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_shift_d = i_Data;
                    tx_par_d   = (^i_Data) ^ ODD_INV;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_idx_d   = '0;
                    tx_d       = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == IDX_W'(DATA_BITS - 1)) begin
                        tx_idx_d = '0;
                        if (HAS_PARITY) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_idx_d   = tx_idx + IDX_W'(1);
                        tx_shift_d = {1'b0, tx_shift[DATA_BITS-1:1]};
                        tx_d       = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_STOP;
                    tx_idx_d   = '0;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_idx == IDX_W'(STOP_BITS - 1)) begin
                        tx_state_d = TX_IDLE;
                        busy_d     = 1'b0;
                    end else begin
                        tx_idx_d = tx_idx + IDX_W'(1);
                    end
                    tx_d = 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // ---------------- RX ----------------
    logic                 rx_meta, rx_sync, rx_prev;
    rx_state_t            rx_state, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_d;
    logic [IDX_W-1:0]     rx_idx, rx_idx_d;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
    logic                 rx_par_bad, rx_par_bad_d;
    logic                 rx_push_q, rx_push_d;
    logic                 fe_set_q, fe_set_d;
    logic                 pe_set_q, pe_set_d;
    logic                 rx_bit_end;
    logic                 fifo_full, fifo_empty;
    logic                 ovr_set_c;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shift   <= '0;
            rx_par_bad <= 1'b0;
            rx_push_q  <= 1'b0;
            fe_set_q   <= 1'b0;
            pe_set_q   <= 1'b0;
        end else begin
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_idx     <= rx_idx_d;
            rx_shift   <= rx_shift_d;
            rx_par_bad <= rx_par_bad_d;
            rx_push_q  <= rx_push_d;
            fe_set_q   <= fe_set_d;
            pe_set_q   <= pe_set_d;
        end
    end

    // Frame outcome is decided at the first stop-bit sample; results are
    // registered so FIFO and flags update one cycle later.
    always_comb begin
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt;
        rx_idx_d     = rx_idx;
        rx_shift_d   = rx_shift;
        rx_par_bad_d = rx_par_bad;
        rx_push_d    = 1'b0;
        fe_set_d     = 1'b0;
        pe_set_d     = 1'b0;
        rx_bit_end   = (rx_cnt == CNT_W'(BIT_PERIOD - 1));
        if (rx_state == RX_DATA || rx_state == RX_PARITY || rx_state == RX_STOP) begin
            rx_cnt_d = rx_bit_end ? '0 : rx_cnt + CNT_W'(1);
        end
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt == CNT_W'(HALF_PERIOD - 1)) begin
                    rx_cnt_d     = '0;
                    rx_idx_d     = '0;
                    rx_par_bad_d = 1'b0;
                    rx_state_d   = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == IDX_W'(DATA_BITS - 1)) begin
                        rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx + IDX_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_par_bad_d = rx_sync ^ (^rx_shift) ^ ODD_INV;
                    rx_state_d   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (!rx_sync) begin
                        fe_set_d   = 1'b1;
                        rx_state_d = RX_BREAK;
                    end else begin
                        rx_state_d = RX_IDLE;
                        pe_set_d   = rx_par_bad;
                        rx_push_d  = !rx_par_bad;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_sync) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Write      (rx_push_q),
        .i_Write_Data (rx_shift),
        .i_Read       (i_Read_Data),
        .o_Data       (o_Data),
        .o_Count      (o_FIFO_Count),
        .o_Full       (fifo_full),
        .o_Empty      (fifo_empty)
    );

    assign o_Data_Ready = ~fifo_empty;
    // A full FIFO only loses data when nothing is popped in the push cycle.
    assign ovr_set_c    = rx_push_q && fifo_full && !i_Read_Data;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Framing_Error <= 1'b0;
            o_Parity_Error  <= 1'b0;
            o_Overrun       <= 1'b0;
        end else begin
            o_Framing_Error <= fe_set_q  | (o_Framing_Error & ~i_Clear_Errors);
            o_Parity_Error  <= pe_set_q  | (o_Parity_Error  & ~i_Clear_Errors);
            o_Overrun       <= ovr_set_c | (o_Overrun       & ~i_Clear_Errors);
        end
    end

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param: three configurations (8N1 at 868
// cycles/bit, 7E2 and 8O1/depth-4 at 16 cycles/bit) against a frame-level model.
module tb_uart_param;

    localparam int unsigned RBP = 16;

    logic clk;
    logic rst, rst2;
    int   errors, checks;

    logic st0, st1, st2;
    logic [7:0] din0, din1, din2;
    logic tx0, tx1, tx2, b0, b1, b2;
    logic [7:0] q0, q2;
    logic [6:0] q1;
    logic rdy0, rdy1, rdy2;
    logic [4:0] cnt0, cnt1;
    logic [2:0] cnt2;
    logic fe0, fe1, fe2, pe0, pe1, pe2, ov0, ov1, ov2;
    logic line2, loop_en, rdreq2, clr2, rx2;

    assign rx2 = loop_en ? tx2 : line2;

    uart_param u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Start(st0), .i_Data(din0),
        .o_TX(tx0), .o_Busy_TX(b0), .i_RX(1'b1), .i_Read_Data(1'b0),
        .o_Data(q0), .o_Data_Ready(rdy0), .o_FIFO_Count(cnt0),
        .i_Clear_Errors(1'b0), .o_Framing_Error(fe0), .o_Parity_Error(pe0), .o_Overrun(ov0)
    );

    uart_param #(.CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(2), .RX_FIFO_DEPTH(16)) u_7e2 (
        .i_Clock(clk), .i_Reset(rst), .i_Start(st1), .i_Data(din1[6:0]),
        .o_TX(tx1), .o_Busy_TX(b1), .i_RX(1'b1), .i_Read_Data(1'b0),
        .o_Data(q1), .o_Data_Ready(rdy1), .o_FIFO_Count(cnt1),
        .i_Clear_Errors(1'b0), .o_Framing_Error(fe1), .o_Parity_Error(pe1), .o_Overrun(ov1)
    );

    uart_param #(.CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
                 .PARITY(1), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_8o1 (
        .i_Clock(clk), .i_Reset(rst2), .i_Start(st2), .i_Data(din2),
        .o_TX(tx2), .o_Busy_TX(b2), .i_RX(rx2), .i_Read_Data(rdreq2),
        .o_Data(q2), .o_Data_Ready(rdy2), .o_FIFO_Count(cnt2),
        .i_Clear_Errors(clr2), .o_Framing_Error(fe2), .o_Parity_Error(pe2), .o_Overrun(ov2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_tx(input int id);
        case (id)
            0: return tx0;
            1: return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic get_busy(input int id);
        case (id)
            0: return b0;
            1: return b1;
            default: return b2;
        endcase
    endfunction

    task automatic set_start(input int id, input logic s, input logic [7:0] d);
        case (id)
            0: begin st0 = s; din0 = d; end
            1: begin st1 = s; din1 = d; end
            default: begin st2 = s; din2 = d; end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tx0, b0, rdy0, fe0, pe0, ov0} !== 6'b100000 || cnt0 !== 5'd0 || q0 !== 8'd0) begin
            errors++;
            $display("FAIL reset_8n1 tx/busy/rdy/fe/pe/ov=%b cnt=%0d data=%h expected 100000/0/00",
                     {tx0, b0, rdy0, fe0, pe0, ov0}, cnt0, q0);
        end
        checks++;
        if ({tx1, b1, rdy1, fe1, pe1, ov1} !== 6'b100000 || cnt1 !== 5'd0 || q1 !== 7'd0) begin
            errors++;
            $display("FAIL reset_7e2 tx/busy/rdy/fe/pe/ov=%b cnt=%0d data=%h expected 100000/0/00",
                     {tx1, b1, rdy1, fe1, pe1, ov1}, cnt1, q1);
        end
        checks++;
        if ({tx2, b2, rdy2, fe2, pe2, ov2} !== 6'b100000 || cnt2 !== 3'd0 || q2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_8o1 tx/busy/rdy/fe/pe/ov=%b cnt=%0d data=%h expected 100000/0/00",
                     {tx2, b2, rdy2, fe2, pe2, ov2}, cnt2, q2);
        end
        rst = 1'b0; rst2 = 1'b0;
    endtask

    // Sends one frame on instance id and checks every cycle of it against the
    // bit sequence built from the frame format. poke injects an i_Start mid-frame.
    task automatic tx_frame(input int id, input logic [7:0] d, input int bp, input int db,
                            input int par, input int sb, input bit poke);
        bit bits[$];
        int bad[16];
        int busy_bad, guard, L;
        logic p;
        guard = 0;
        while (get_busy(id) === 1'b1 && guard < 20000) begin
            @(posedge clk); #1; guard++;
        end
        checks++;
        if (guard >= 20000) begin
            errors++;
            $display("FAIL tx_idle_wait inst=%0d busy stuck at %b expected 0", id, get_busy(id));
        end
        bits.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < db; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par != 0) bits.push_back(p ^ (par == 1));
        for (int i = 0; i < sb; i++) bits.push_back(1'b1);
        for (int i = 0; i < 16; i++) bad[i] = 0;
        busy_bad = 0;
        L = bits.size() * bp;
        set_start(id, 1'b1, d);
        @(posedge clk); #1;
        set_start(id, 1'b0, d);
        for (int k = 0; k < L; k++) begin
            if (get_tx(id) !== bits[k / bp]) bad[k / bp]++;
            if (get_busy(id) !== 1'b1) busy_bad++;
            if (poke && k == L / 2) set_start(id, 1'b1, ~d);
            if (poke && k == L / 2 + 1) set_start(id, 1'b0, d);
            @(posedge clk); #1;
        end
        for (int b = 0; b < bits.size(); b++) begin
            checks++;
            if (bad[b] != 0) begin
                errors++;
                $display("FAIL tx_bit inst=%0d bit=%0d wrong_cycles=%0d expected=%b", id, b, bad[b], bits[b]);
            end
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL tx_busy_len inst=%0d low_cycles_in_frame=%0d expected 0 over %0d", id, busy_bad, L);
        end
        checks++;
        if (get_busy(id) !== 1'b0 || get_tx(id) !== 1'b1) begin
            errors++;
            $display("FAIL tx_frame_end inst=%0d busy=%b tx=%b expected busy=0 tx=1", id, get_busy(id), get_tx(id));
        end
        if (poke) begin
            busy_bad = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (get_busy(id) !== 1'b0) busy_bad++;
            end
            checks++;
            if (busy_bad != 0) begin
                errors++;
                $display("FAIL tx_start_ignored inst=%0d busy_cycles=%0d expected 0", id, busy_bad);
            end
        end
    endtask

    // Drives one 8O1 frame onto u_8o1's RX pin; pop_at pulses i_Read_Data in the
    // cycle following that many edges after the falling start edge.
    task automatic send_line(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int pop_at);
        bit bits[$];
        int total;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        bits.push_back(~(^d) ^ bad_par);
        bits.push_back(bad_stop ? 1'b0 : 1'b1);
        total = bits.size() * RBP;
        @(posedge clk); #1;
        line2 = bits[0];
        for (int c = 1; c < total; c++) begin
            @(posedge clk); #1;
            line2  = bits[c / RBP];
            rdreq2 = (c == pop_at);
        end
        @(posedge clk); #1;
        line2 = 1'b1; rdreq2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drain(input logic [7:0] exp[$], input string tag);
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (rdy2 !== 1'b1 || q2 !== exp[i]) begin
                errors++;
                $display("FAIL %s_pop%0d ready=%b data=%h expected ready=1 data=%h", tag, i, rdy2, q2, exp[i]);
            end
            rdreq2 = 1'b1;
            @(posedge clk); #1;
            rdreq2 = 1'b0;
        end
        checks++;
        if (rdy2 !== 1'b0 || cnt2 !== 3'd0) begin
            errors++;
            $display("FAIL %s_empty ready=%b count=%0d expected 0/0", tag, rdy2, cnt2);
        end
    endtask

    task automatic test_tx_8n1();
        tx_frame(0, 8'hA5, 868, 8, 0, 1, 1'b0);
    endtask

    task automatic test_tx_7e2();
        tx_frame(1, 8'h41, RBP, 7, 2, 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) tx_frame(1, 8'($urandom), RBP, 7, 2, 2, 1'b0);
    endtask

    task automatic test_loopback();
        logic [7:0] exp[$];
        int guard;
        exp = '{8'h00, 8'hFF, 8'h3C, 8'($urandom)};
        loop_en = 1'b1;
        foreach (exp[i]) tx_frame(2, exp[i], RBP, 8, 1, 1, 1'b0);
        guard = 0;
        while (cnt2 !== 3'd4 && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        loop_en = 1'b0;
        checks++;
        if (cnt2 !== 3'd4 || {fe2, pe2, ov2} !== 3'b000) begin
            errors++;
            $display("FAIL loopback_count count=%0d fe/pe/ov=%b expected 4/000", cnt2, {fe2, pe2, ov2});
        end
        drain(exp, "loopback");
    endtask

    task automatic test_rx_errors();
        @(posedge clk); #1;
        line2 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        line2 = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (cnt2 !== 3'd0 || rdy2 !== 1'b0 || {fe2, pe2, ov2} !== 3'b000) begin
            errors++;
            $display("FAIL rx_glitch count=%0d ready=%b flags=%b expected 0/0/000", cnt2, rdy2, {fe2, pe2, ov2});
        end
        send_line(8'($urandom), 1'b0, 1'b1, -1);
        checks++;
        if (fe2 !== 1'b1 || pe2 !== 1'b0 || cnt2 !== 3'd0) begin
            errors++;
            $display("FAIL rx_framing fe=%b pe=%b count=%0d expected 1/0/0", fe2, pe2, cnt2);
        end
        send_line(8'($urandom), 1'b1, 1'b0, -1);
        checks++;
        if (pe2 !== 1'b1 || cnt2 !== 3'd0) begin
            errors++;
            $display("FAIL rx_parity pe=%b count=%0d expected 1/0", pe2, cnt2);
        end
        clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        checks++;
        if (fe2 !== 1'b0 || pe2 !== 1'b0) begin
            errors++;
            $display("FAIL rx_clear fe=%b pe=%b expected 0/0", fe2, pe2);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp[$];
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            if (exp.size() < 4) exp.push_back(d);
            send_line(d, 1'b0, 1'b0, -1);
        end
        checks++;
        if (cnt2 !== 3'd4 || ov2 !== 1'b1 || q2 !== exp[0]) begin
            errors++;
            $display("FAIL overrun count=%0d ov=%b head=%h expected 4/1/%h", cnt2, ov2, q2, exp[0]);
        end
        drain(exp, "overrun");
        clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        checks++;
        if (ov2 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear ov=%b expected 0", ov2);
        end
    endtask

    task automatic test_fifo_boundaries();
        logic [7:0] exp[$];
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            exp.push_back(d);
            send_line(d, 1'b0, 1'b0, -1);
        end
        checks++;
        if (cnt2 !== 3'd4) begin
            errors++;
            $display("FAIL fill_count count=%0d expected 4", cnt2);
        end
        d = 8'($urandom);
        exp.push_back(d);
        void'(exp.pop_front());
        // stop sample lands 3 + RBP/2 + 10*RBP edges after the start edge
        send_line(d, 1'b0, 1'b0, 3 + RBP / 2 + 10 * RBP);
        checks++;
        if (cnt2 !== 3'd4 || ov2 !== 1'b0 || q2 !== exp[0]) begin
            errors++;
            $display("FAIL full_pop_push count=%0d ov=%b head=%h expected 4/0/%h", cnt2, ov2, q2, exp[0]);
        end
        drain(exp, "full_pop");
        rdreq2 = 1'b1;
        @(posedge clk); #1;
        rdreq2 = 1'b0;
        checks++;
        if (cnt2 !== 3'd0 || rdy2 !== 1'b0 || ov2 !== 1'b0) begin
            errors++;
            $display("FAIL pop_empty count=%0d ready=%b ov=%b expected 0/0/0", cnt2, rdy2, ov2);
        end
    endtask

    task automatic test_reset_mid_tx();
        int bad;
        send_line(8'($urandom), 1'b0, 1'b0, -1);
        send_line(8'($urandom), 1'b1, 1'b0, -1);
        checks++;
        if (cnt2 !== 3'd1 || pe2 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset count=%0d pe=%b expected 1/1", cnt2, pe2);
        end
        set_start(2, 1'b1, 8'($urandom));
        @(posedge clk); #1;
        set_start(2, 1'b0, 8'h00);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (b2 !== 1'b1) begin
            errors++;
            $display("FAIL mid_tx_busy busy=%b expected 1", b2);
        end
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        checks++;
        if ({tx2, b2, rdy2, fe2, pe2, ov2} !== 6'b100000 || cnt2 !== 3'd0 || q2 !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_tx tx/busy/rdy/fe/pe/ov=%b cnt=%0d data=%h expected 100000/0/00",
                     {tx2, b2, rdy2, fe2, pe2, ov2}, cnt2, q2);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx2 !== 1'b1 || b2 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_tx_idle bad_cycles=%0d expected 0", bad);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst = 1'b1; rst2 = 1'b1;
        st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
        din0 = '0; din1 = '0; din2 = '0;
        line2 = 1'b1; loop_en = 1'b0; rdreq2 = 1'b0; clr2 = 1'b0;
        test_reset();
        test_tx_8n1();
        test_tx_7e2();
        test_back_to_back();
        test_loopback();
        test_rx_errors();
        test_overrun();
        test_fifo_boundaries();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
